// File: rtl/aes_tb_pkg.sv
// Shared constants and FSM encoding for the aes_128 response-side checker.
package aes_tb_pkg;

  localparam int AES_WIDTH = 128;
  localparam int AES_LATENCY = 21;
  localparam logic [AES_WIDTH-1:0] MISR_POLY = 128'h87;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } misr_state_t;

endpackage

// File: rtl/aes_response_misr_misr.sv
// WIDTH-bit multiple-input signature register: Galois-style shift with POLY
// feedback, then XOR of the incoming data word.
import aes_tb_pkg::*;

module misr #(
  parameter int WIDTH = AES_WIDTH,
  parameter logic [WIDTH-1:0] POLY = MISR_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] sig
);

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] sig_next;

  assign shifted  = {sig[WIDTH-2:0], 1'b0};
  assign sig_next = shifted ^ (sig[WIDTH-1] ? POLY : '0) ^ data;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig <= seed;
    end else if (load) begin
      sig <= seed;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/aes_response_misr.sv
// Delays in_valid by the cipher latency, folds matching aes_128 outputs into a
// MISR and reports pass/fail after the programmed number of captures.
import aes_tb_pkg::*;

module aes_response_misr #(
  parameter int LATENCY = AES_LATENCY,
  parameter int WIDTH = AES_WIDTH,
  parameter logic [WIDTH-1:0] SEED = '0,
  parameter logic [WIDTH-1:0] POLY = MISR_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      num_tests,
  input  logic [WIDTH-1:0] expected_sig,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             overrun,
  output logic [WIDTH-1:0] signature,
  output logic [31:0]      capture_count
);

  misr_state_t      state;
  logic [LATENCY-1:0] dly;
  logic [LATENCY:0]   dly_ext;
  logic             cap_valid;
  logic [31:0]      num_q;
  logic [WIDTH-1:0] expected_q;
  logic [31:0]      count_inc;
  logic             capture;
  logic [WIDTH-1:0] sig_next;

  assign dly_ext   = {dly, in_valid};
  assign cap_valid = dly[LATENCY-1];
  assign count_inc = capture_count + 32'd1;
  assign capture   = (state == ST_COLLECT) && cap_valid && !start;

  // Same step as the compactor; needed here so pass registers with the last update.
  assign sig_next = {signature[WIDTH-2:0], 1'b0}
                    ^ (signature[WIDTH-1] ? POLY : '0) ^ dut_out;

  misr #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (start),
    .seed (SEED),
    .en   (capture),
    .data (dut_out),
    .sig  (signature)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      dly           <= '0;
      num_q         <= '0;
      expected_q    <= '0;
      capture_count <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      overrun       <= 1'b0;
    end else if (start) begin
      // Restart drops anything in flight, including a capture due this cycle.
      dly           <= '0;
      num_q         <= num_tests;
      expected_q    <= expected_sig;
      capture_count <= '0;
      overrun       <= 1'b0;
      if (num_tests == 32'd0) begin
        state <= ST_DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        pass  <= (SEED == expected_sig);
      end else begin
        state <= ST_COLLECT;
        busy  <= 1'b1;
        done  <= 1'b0;
        pass  <= 1'b0;
      end
    end else begin
      dly <= dly_ext[LATENCY-1:0];
      case (state)
        ST_COLLECT: begin
          if (cap_valid) begin
            capture_count <= count_inc;
            if (count_inc == num_q) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (sig_next == expected_q);
            end
          end
        end
        ST_DONE: begin
          if (cap_valid) overrun <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_response_misr.sv
// Directed bench for aes_response_misr: table of complete runs plus hand-written
// sequences for latency, restart, reset and zero-count corner cases.
module tb_aes_response_misr;

  localparam int W = 128;
  localparam int LAT = 21;
  localparam logic [W-1:0] MSB_SEED = {1'b1, 127'b0};

  logic         clk = 1'b0;
  logic         rst, start, in_valid;
  logic [31:0]  num_tests;
  logic [W-1:0] expected_sig, stim_data, dut_out;

  logic         busy, done, pass, overrun;
  logic [W-1:0] signature;
  logic [31:0]  capture_count;
  logic         s_busy, s_done, s_pass, s_overrun;
  logic [W-1:0] s_signature;
  logic [31:0]  s_capture_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  aes_response_misr u_dut (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .expected_sig(expected_sig), .in_valid(in_valid), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .overrun(overrun),
    .signature(signature), .capture_count(capture_count)
  );

  aes_response_misr #(.SEED(MSB_SEED)) u_seed (
    .clk(clk), .rst(rst), .start(start), .num_tests(num_tests),
    .expected_sig(expected_sig), .in_valid(in_valid), .dut_out(dut_out),
    .busy(s_busy), .done(s_done), .pass(s_pass), .overrun(s_overrun),
    .signature(s_signature), .capture_count(s_capture_count)
  );

  // Stand-in for aes_128: stimulus reappears on dut_out LAT edges later.
  logic [W-1:0] dpipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) dpipe[i] <= dpipe[i-1];
    dpipe[0] <= stim_data;
  end
  assign dut_out = dpipe[LAT-1];

  typedef struct {
    logic [31:0]       n;
    logic [W-1:0]      exp_in;
    int                np;
    logic [3:0][W-1:0] d;
    int                gap;
    logic [W-1:0]      want_sig;
    logic [31:0]       want_cnt;
    logic              want_pass;
    logic              want_ovr;
  } vec_t;

  vec_t vecs [5];

  function automatic vec_t mk(logic [31:0] n, logic [W-1:0] e, int np,
                              logic [W-1:0] d0, logic [W-1:0] d1,
                              logic [W-1:0] d2, int gap, logic [W-1:0] ws,
                              logic [31:0] wc, logic wp, logic wo);
    vec_t v;
    v.n = n; v.exp_in = e; v.np = np;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = '0;
    v.gap = gap; v.want_sig = ws; v.want_cnt = wc;
    v.want_pass = wp; v.want_ovr = wo;
    return v;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic start_run(logic [31:0] n, logic [W-1:0] e);
    start = 1'b1; num_tests = n; expected_sig = e;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse(logic [W-1:0] d);
    in_valid = 1'b1; stim_data = d;
    @(negedge clk);
    in_valid = 1'b0; stim_data = '0;
  endtask

  task automatic wait_done(int max_cycles, string name);
    int i = 0;
    while (!done && i < max_cycles) begin
      @(negedge clk);
      i++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_tests = '0;
    expected_sig = '0; stim_data = '0;
    for (int i = 0; i < LAT; i++) dpipe[i] = '0;

    vecs[0] = mk(1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 0);
    vecs[1] = mk(2, 2, 2, 1, 1, 0, 0, 3, 2, 0, 0);
    vecs[2] = mk(2, 128'h87, 2, MSB_SEED, 0, 0, 3, 128'h87, 2, 1, 0);
    vecs[3] = mk(3, 4, 3, 1, 2, 4, 1, 4, 3, 1, 0);
    vecs[4] = mk(2, 9, 3, 5, 3, 128'hff, 0, 9, 2, 1, 1);

    // Reset, with start asserted alongside it in the last cycle.
    repeat (2) @(negedge clk);
    start = 1'b1; num_tests = 5;
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_sig", signature, 0);
    chk("rst_cnt", capture_count, 0);
    chk("rst_seed_sig", s_signature, MSB_SEED);

    for (int v = 0; v < 5; v++) begin
      start_run(vecs[v].n, vecs[v].exp_in);
      chk($sformatf("v%0d_busy_on", v), busy, 1);
      for (int k = 0; k < vecs[v].np; k++) begin
        pulse(vecs[v].d[k]);
        repeat (vecs[v].gap) @(negedge clk);
      end
      wait_done(60, $sformatf("v%0d_done", v));
      chk($sformatf("v%0d_sig", v), signature, vecs[v].want_sig);
      chk($sformatf("v%0d_cnt", v), capture_count, vecs[v].want_cnt);
      chk($sformatf("v%0d_pass", v), pass, vecs[v].want_pass);
      chk($sformatf("v%0d_busy_off", v), busy, 0);
      repeat (30) @(negedge clk);
      chk($sformatf("v%0d_ovr", v), overrun, vecs[v].want_ovr);
      chk($sformatf("v%0d_sig_frozen", v), signature, vecs[v].want_sig);
    end

    // Latency: capture lands exactly LAT edges after in_valid is sampled.
    start_run(1, 0);
    in_valid = 1'b1; stim_data = 7;
    @(negedge clk);
    in_valid = 1'b0; stim_data = '0;
    ok = (capture_count == 0);
    for (int i = 1; i < LAT; i++) begin
      @(negedge clk);
      if (capture_count != 0) ok = 1'b0;
    end
    chk("lat_early_cnt", ok, 1);
    chk("lat_early_busy", busy, 1);
    @(negedge clk);
    chk("lat_cnt", capture_count, 1);
    chk("lat_sig", signature, 7);
    chk("lat_done", done, 1);
    chk("lat_pass", pass, 0);
    pulse(9);
    repeat (LAT - 1) @(negedge clk);
    chk("ovr_early", overrun, 0);
    @(negedge clk);
    chk("ovr_set", overrun, 1);
    chk("ovr_sig", signature, 7);
    chk("ovr_cnt", capture_count, 1);

    // Zero captures: done/pass one cycle after start, busy never raised.
    start_run(0, 0);
    chk("zero_done", done, 1);
    chk("zero_pass", pass, 1);
    chk("zero_ovr_clr", overrun, 0);
    chk("zero_seed_pass", s_pass, 0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (busy) ok = 1'b0;
      @(negedge clk);
    end
    chk("zero_busy", ok, 0 == 0);

    // Feedback path through the top bit of the seed.
    start_run(1, 128'h87);
    pulse(0);
    wait_done(60, "fb_done");
    chk("fb_seed_sig", s_signature, 128'h87);
    chk("fb_seed_pass", s_pass, 1);
    chk("fb_seed_done", s_done, 1);
    chk("fb_sig", signature, 0);
    chk("fb_pass", pass, 0);

    // Restart on the very cycle a capture is due: capture is discarded.
    start_run(1, 0);
    pulse(5);
    repeat (LAT - 1) @(negedge clk);
    start_run(1, 0);
    chk("rs_cnt", capture_count, 0);
    chk("rs_sig", signature, 0);
    chk("rs_busy", busy, 1);
    chk("rs_done", done, 0);
    repeat (25) @(negedge clk);
    chk("rs_no_late_cap", capture_count, 0);

    // Reset mid-run with pulses still in flight.
    start_run(2, 0);
    pulse(1);
    pulse(1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_pass", pass, 0);
    chk("mr_ovr", overrun, 0);
    chk("mr_sig", signature, 0);
    chk("mr_cnt", capture_count, 0);
    start_run(1, 3);
    repeat (40) @(negedge clk);
    chk("mr_stale_cnt", capture_count, 0);
    chk("mr_stale_busy", busy, 1);
    pulse(3);
    wait_done(60, "mr_done2");
    chk("mr_sig2", signature, 3);
    chk("mr_pass2", pass, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_response_misr.md
# aes_response_misr

Response-side companion to the LFSR stimulus generators that drive `aes_128`. It tracks which `aes_128` input cycles carried valid stimulus through a delay line matched to the cipher's pipeline latency. It compacts each resulting ciphertext into a 128-bit multiple-input signature register (MISR). After a programmed number of captures it compares the signature against an expected value and reports pass/fail. This closes the loop for long randomized runs without dumping every ciphertext.

## Interface
Parameters:
- `LATENCY`, 21: cycles from stimulus applied at `aes_128` inputs to the corresponding `out`.
- `WIDTH`, 128: data and signature width.
- `SEED`, 128'h0: MISR initial value.
- `POLY`, 128'h87: feedback taps, x^128+x^7+x^2+x+1 (bits 7, 2, 1, 0).

Ports:
- `clk`, in, 1: sole clock, same clock as `aes_128`.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: one-cycle pulse; arms a new run.
- `num_tests`, in, 32: captures per run; sampled on `start`.
- `expected_sig`, in, WIDTH: golden signature; sampled on `start`.
- `in_valid`, in, 1: high in cycles where valid stimulus is presented to `aes_128`.
- `dut_out`, in, WIDTH: `aes_128.out`.
- `busy`, out, 1: run in progress.
- `done`, out, 1: run complete; held until next `start` or `rst`.
- `pass`, out, 1: signature matched; valid only while `done`=1.
- `overrun`, out, 1: sticky; a delayed valid arrived while in DONE.
- `signature`, out, WIDTH: current MISR value.
- `capture_count`, out, 32: captures folded so far in the current run.

## Operation
- FSM states: IDLE, COLLECT, DONE.
- Reset: FSM goes to IDLE; `signature`=SEED; delay line cleared; `busy`, `done`, `pass`, `overrun`, `capture_count` all 0.
- `start` in any state (a restart aborts an active run):
  - loads `signature`=SEED, clears `capture_count`, `overrun`, `done`, `pass`, and the whole delay line;
  - latches `num_tests` and `expected_sig`.
  - If `num_tests`==0, go to DONE. Otherwise go to COLLECT.
- Delay line: LATENCY-stage shift register of `in_valid`. It shifts every cycle in all states. Its tail is `cap_valid`.
- COLLECT: on `cap_valid`, update the MISR:
  - fb = signature[WIDTH-1];
  - signature ← ({signature[WIDTH-2:0],1'b0} ^ (fb ? POLY : 0)) ^ dut_out;
  - `capture_count` += 1.
  - When the increment reaches the latched count, go to DONE. The final capture is included.
- Entry to DONE: `pass` = (new signature == latched expected). `busy` goes to 0 and `done` goes to 1 in the same cycle.
- DONE: `signature` and `capture_count` frozen. `cap_valid`=1 sets `overrun`.
- IDLE: `cap_valid` ignored; nothing updates.
- `in_valid` gaps are legal; only valid cycles are captured.

## Timing
- `in_valid` high at edge t causes a capture of `dut_out` at edge t+LATENCY.
- `signature` and `capture_count` are visible from t+LATENCY+1.
- `busy` is high from the cycle after `start` until the cycle `done` rises.
- `done`/`pass` rise in the cycle after the final capture edge, i.e. registered together with the last signature update.
- `num_tests`==0: `done`=1, `pass`=(SEED==expected) one cycle after `start`.
- `start` and `cap_valid` in the same cycle: `start` wins. The capture is discarded and the delay line is cleared.
- `rst` and `start` in the same cycle: `rst` wins.
- `capture_count` cannot wrap: DONE is reached at `num_tests` ≤ 2^32−1.

## Structure
- Shared package `aes_tb_pkg`:
  - `AES_WIDTH`=128, `AES_LATENCY`=21, `MISR_POLY`=128'h87;
  - FSM state enum `misr_state_t`.
- One natural sub-module `misr`: the WIDTH-bit compactor.
  - Ports: `clk`, `rst`, `load`, `seed`, `en`, `data`, `sig`.
  - Parameter: POLY.
- FSM, delay line and counter live in the top.

## Test plan
- Seed 0, `num_tests`=1, one `in_valid` pulse with `dut_out`=1 at capture → `signature`=1; `expected_sig`=1 gives `done`=1, `pass`=1.
- Seed 0, `num_tests`=2, two back-to-back pulses, both data 1 → `signature`=3 and `capture_count`=2; `expected_sig`=2 gives `pass`=0.
- SEED=128'h8000…0, `num_tests`=1, data 0 → `signature`=128'h87 (feedback path).
- Latency: `in_valid` pulse at cycle 0 → `capture_count` stays 0 through cycle 21 and reads 1 at cycle 22. A second `in_valid` after DONE sets `overrun`=1 21 cycles later; `signature` is unchanged.
- `num_tests`=0, `expected_sig`=SEED → `done`=`pass`=1 one cycle after `start`, `busy` never high.
- `rst` mid-COLLECT, then `start` again: all outputs return to reset values. The new run ignores `in_valid` pulses issued before the reset; those pulses produce no captures.
